egg_timer_ctrl: RTL and testbench
=================================

# egg_timer_ctrl

Sequencing controller for the egg timer. It takes the divider's 1 Hz and 500 Hz strobes and the debounced push-button strobes, and runs the set/run/pause/alarm state machine. It holds the remaining time as four BCD digits for the display multiplexer. It sits between the clock divider and the seven-segment driver and is the only block that owns time state.

## Interface
Parameters:
- DEFAULT_MIN, 5: minutes preset loaded at reset (1..MAX_MIN)
- MAX_MIN, 59: highest settable minute value (1..59)
- ALARM_SECS, 30: alarm duration in 1 Hz strobes (used only with timeout feature)
- BLINK_DIV, 125: pulse_500Hz strobes per blank toggle (125 gives a 2 Hz blink)

Ports:
- CLK100Mhz  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- pulse_1Hz  in  1  one-cycle strobe, synchronous to CLK100Mhz
- pulse_500Hz  in  1  one-cycle strobe, synchronous to CLK100Mhz
- btn_start  in  1  one-cycle debounced strobe: start/pause toggle
- btn_min  in  1  one-cycle strobe: minute increment
- btn_sec  in  1  one-cycle strobe: second increment
- btn_clear  in  1  one-cycle strobe: clear/abort
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD remaining time
- running  out  1  high in RUN
- alarm  out  1  high in ALARM
- blank  out  1  display blank request (blink)
- state  out  3  encoded FSM state, for debug LEDs

## Operation
- States: IDLE, RUN, PAUSE, ALARM.
- Button priority within one cycle: btn_clear > btn_start > btn_min > btn_sec. Only the highest-priority button acts.
- IDLE
  - btn_min: minutes +1; MAX_MIN wraps to 00.
  - btn_sec: seconds +1; 59 wraps to 00; no carry into minutes.
  - btn_clear: time becomes 00:00.
  - btn_start with time nonzero: copy time into the preset register, go to RUN.
  - btn_start at 00:00: ignored.
- RUN
  - pulse_1Hz: decrement time by one second.
  - Decrement from 00:01 to 00:00 enters ALARM on the same edge.
  - btn_start: go to PAUSE.
  - btn_clear: time becomes 00:00, go to IDLE.
  - btn_min and btn_sec: ignored.
- PAUSE
  - Time is held.
  - btn_start: go to RUN.
  - btn_clear: time becomes 00:00, go to IDLE.
  - btn_min and btn_sec: ignored.
- ALARM
  - alarm=1, and blank toggles every BLINK_DIV pulse_500Hz strobes.
  - Any button: reload time from the preset, go to IDLE, blank=0.
- BCD decrement rules:
  - A ones digit at 0 becomes 9 and borrows.
  - sec_tens at 0 becomes 5 and borrows into minutes.
  - Minutes never underflow, because ALARM is entered at 00:00.
- Digit ranges are invariant: ones 0-9, sec_tens 0-5, minute value ≤ MAX_MIN.
- Simultaneous events in RUN:
  - pulse_1Hz with btn_start: the decrement is applied and the FSM goes to PAUSE.
  - pulse_1Hz with btn_clear: clear wins, and no ALARM is raised even at 00:01.
- blank is 0 in every state except ALARM. The blink counter resets on entry to ALARM.

## Timing
- All outputs are registered. A response appears on the first CLK100Mhz edge after the strobe cycle, giving 1-cycle latency.
- The first decrement occurs on the first pulse_1Hz after start. Phase is not realigned, so the first second is 0-1 s long.
- Reset values:
  - state=IDLE, time=DEFAULT_MIN:00 in BCD, preset=DEFAULT_MIN:00.
  - running=0, alarm=0, blank=0, blink and alarm counters 0.
- Reset asserted mid-RUN or mid-ALARM returns to the reset values immediately (asynchronous). It releases to IDLE.
- Strobes arriving during reset are lost.

## Configuration
- EGG_ALARM_TIMEOUT_EN defined:
  - A counter counts pulse_1Hz strobes while in ALARM.
  - After ALARM_SECS strobes the FSM returns to IDLE with time reloaded from the preset, exactly as if a button were pressed.
  - A button press still exits early.
- Not defined: ALARM persists until a button is pressed, and the timeout counter is not built.

## Structure
- Shared package egg_timer_pkg holds:
  - the state enum (IDLE=0, RUN=1, PAUSE=2, ALARM=3)
  - the BCD digit typedef (4-bit)
  - constants SEC_TENS_MAX=5 and DIGIT_MAX=9
- Sub-module bcd_mod60_digit_pair: a two-digit BCD pair with increment, decrement, load and clear.
  - Outputs a borrow flag (value was 00 on decrement).
  - The tens-digit limit is a parameter.
  - Seconds instance: tens limit 5, ones limit 9.
  - Minutes instance: wraps at MAX_MIN for increment.
- The controller instantiates two pairs and chains the seconds borrow into the minutes decrement enable.

## Test plan
- Reset released, no buttons -> 05:00, state IDLE, all flags 0. 300 pulse_1Hz strobes -> time unchanged.
- Set 01:05 via btn_clear, btn_min×1, btn_sec×5, then btn_start. 65 pulse_1Hz strobes -> running until 00:00, alarm=1 on strobe 65, and blank toggles after 125 pulse_500Hz strobes.
- RUN at 10:00, one pulse_1Hz -> 09:59. Continue from 00:10, one strobe -> 00:09. btn_min at 59:00 in IDLE -> 00:00.
- RUN at 02:30: btn_start -> PAUSE. 5 pulse_1Hz strobes -> still 02:30. btn_start -> RUN. btn_clear asserted with pulse_1Hz -> IDLE at 00:00, alarm stays 0.
- ALARM reached from preset 01:05, then btn_sec -> IDLE with time 01:05 and alarm=0. With EGG_ALARM_TIMEOUT_EN, no button -> auto-return after 30 pulse_1Hz strobes.
- btn_start at 00:00 in IDLE -> state stays IDLE. Assert reset_n low mid-RUN at 03:17 -> immediately 05:00 IDLE.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer controller and its BCD digit pairs.
package egg_timer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      ALARM = 3'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t DIGIT_MAX    = 4'd9;

   function automatic bcd_t tens_of(input int unsigned v);
      return bcd_t'(v / 10);
   endfunction

   function automatic bcd_t ones_of(input int unsigned v);
      return bcd_t'(v % 10);
   endfunction

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Strobe/button inputs and display outputs of the egg timer controller.
interface egg_timer_ctrl_if;
   import egg_timer_pkg::*;

   logic       pulse_1Hz;
   logic       pulse_500Hz;
   logic       btn_start;
   logic       btn_min;
   logic       btn_sec;
   logic       btn_clear;
   bcd_t       min_tens;
   bcd_t       min_ones;
   bcd_t       sec_tens;
   bcd_t       sec_ones;
   logic       running;
   logic       alarm;
   logic       blank;
   logic [2:0] state;

   modport master (
      output pulse_1Hz, pulse_500Hz, btn_start, btn_min, btn_sec, btn_clear,
      input  min_tens, min_ones, sec_tens, sec_ones, running, alarm, blank, state
   );

   modport slave (
      input  pulse_1Hz, pulse_500Hz, btn_start, btn_min, btn_sec, btn_clear,
      output min_tens, min_ones, sec_tens, sec_ones, running, alarm, blank, state
   );

endinterface

// File: rtl/bcd_mod60_digit_pair.sv
// Two-digit BCD register with clear > load > decrement > increment; borrow_c flags a decrement from 00.
module bcd_mod60_digit_pair
   import egg_timer_pkg::*;
#(
   parameter int unsigned TENS_MAX = 5,
   parameter int unsigned WRAP_VAL = 59,
   parameter int unsigned RST_VAL  = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  bcd_t load_tens,
   input  bcd_t load_ones,
   input  logic inc,
   input  logic dec,
   output bcd_t tens,
   output bcd_t ones,
   output logic borrow_c
);

   localparam bcd_t WRAP_TENS = tens_of(WRAP_VAL);
   localparam bcd_t WRAP_ONES = ones_of(WRAP_VAL);
   localparam bcd_t TENS_TOP  = bcd_t'(TENS_MAX);

   bcd_t tens_d;
   bcd_t ones_d;

   assign borrow_c = dec && (tens == 4'd0) && (ones == 4'd0);

   always_comb begin
      tens_d = tens;
      ones_d = ones;
      if (clr) begin
         tens_d = 4'd0;
         ones_d = 4'd0;
      end else if (load) begin
         tens_d = load_tens;
         ones_d = load_ones;
      end else if (dec) begin
         if (ones == 4'd0) begin
            ones_d = DIGIT_MAX;
            tens_d = (tens == 4'd0) ? TENS_TOP : tens - 4'd1;
         end else begin
            ones_d = ones - 4'd1;
         end
      end else if (inc) begin
         if (tens == WRAP_TENS && ones == WRAP_ONES) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
         end else if (ones == DIGIT_MAX) begin
            ones_d = 4'd0;
            tens_d = tens + 4'd1;
         end else begin
            ones_d = ones + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens <= tens_of(RST_VAL);
         ones <= ones_of(RST_VAL);
      end else begin
         tens <= tens_d;
         ones <= ones_d;
      end
   end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer set/run/pause/alarm sequencer owning the BCD remaining time.
// Optional alarm auto-timeout: define EGG_ALARM_TIMEOUT_EN.
module egg_timer_ctrl
   import egg_timer_pkg::*;
#(
   parameter int unsigned DEFAULT_MIN = 5,
   parameter int unsigned MAX_MIN     = 59,
   parameter int unsigned ALARM_SECS  = 30,
   parameter int unsigned BLINK_DIV   = 125
) (
   input  logic             CLK100Mhz,
   input  logic             reset_n,
   egg_timer_ctrl_if.slave  bus
);

   localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);

   state_t state_q, state_d;
   logic   running_q, alarm_q, blank_q;
   logic   [BLINK_W-1:0] blink_cnt;

   logic   clr_time, load_time, preset_ld, sec_inc, min_inc, sec_dec;
   logic   sec_borrow, min_borrow_unused, timeout_c;
   logic   btn_any, time_zero, time_one;
   bcd_t   mt, mo, st, so;
   bcd_t   pre_mt, pre_mo, pre_st, pre_so;

   assign btn_any   = bus.btn_clear | bus.btn_start | bus.btn_min | bus.btn_sec;
   assign time_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
   assign time_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

   // Next state and time-register controls.
   always_comb begin
      state_d   = state_q;
      clr_time  = 1'b0;
      load_time = 1'b0;
      preset_ld = 1'b0;
      sec_inc   = 1'b0;
      min_inc   = 1'b0;
      sec_dec   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.btn_clear) begin
               clr_time = 1'b1;
            end else if (bus.btn_start) begin
               if (!time_zero) begin
                  preset_ld = 1'b1;
                  state_d   = RUN;
               end
            end else if (bus.btn_min) begin
               min_inc = 1'b1;
            end else if (bus.btn_sec) begin
               sec_inc = 1'b1;
            end
         end
         RUN: begin
            if (bus.btn_clear) begin
               clr_time = 1'b1;
               state_d  = IDLE;
            end else if (time_zero) begin
               // reachable only by pausing on the 00:01 -> 00:00 strobe
               state_d = ALARM;
            end else begin
               sec_dec = bus.pulse_1Hz;
               if (bus.btn_start) begin
                  state_d = PAUSE;
               end else if (bus.pulse_1Hz && time_one) begin
                  state_d = ALARM;
               end
            end
         end
         PAUSE: begin
            if (bus.btn_clear) begin
               clr_time = 1'b1;
               state_d  = IDLE;
            end else if (bus.btn_start) begin
               state_d = RUN;
            end
         end
         ALARM: begin
            if (btn_any || timeout_c) begin
               load_time = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == RUN);
         alarm_q   <= (state_d == ALARM);
      end
   end

   // Blink divider: restarts on ALARM entry, blank forced low elsewhere.
   always_ff @(posedge CLK100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blank_q   <= 1'b0;
      end else if (state_d != ALARM || state_q != ALARM) begin
         blink_cnt <= '0;
         blank_q   <= 1'b0;
      end else if (bus.pulse_500Hz) begin
         if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blank_q   <= ~blank_q;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

`ifdef EGG_ALARM_TIMEOUT_EN
   localparam int unsigned ALARM_W = $clog2(ALARM_SECS + 1);
   logic [ALARM_W-1:0] alarm_cnt;

   assign timeout_c = (state_q == ALARM) && bus.pulse_1Hz &&
                      (alarm_cnt == ALARM_W'(ALARM_SECS - 1));

   always_ff @(posedge CLK100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         alarm_cnt <= '0;
      end else if (state_q != ALARM) begin
         alarm_cnt <= '0;
      end else if (bus.pulse_1Hz) begin
         alarm_cnt <= alarm_cnt + ALARM_W'(1);
      end
   end
`else
   // Alarm persists until a button; no timeout counter.
   localparam int unsigned ALARM_SECS_UNUSED = ALARM_SECS;
   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge CLK100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         pre_mt <= tens_of(DEFAULT_MIN);
         pre_mo <= ones_of(DEFAULT_MIN);
         pre_st <= 4'd0;
         pre_so <= 4'd0;
      end else if (preset_ld) begin
         pre_mt <= mt;
         pre_mo <= mo;
         pre_st <= st;
         pre_so <= so;
      end
   end

   bcd_mod60_digit_pair #(
      .TENS_MAX (SEC_TENS_MAX),
      .WRAP_VAL (59),
      .RST_VAL  (0)
   ) u_sec (
      .clk       (CLK100Mhz),
      .rst_n     (reset_n),
      .clr       (clr_time),
      .load      (load_time),
      .load_tens (pre_st),
      .load_ones (pre_so),
      .inc       (sec_inc),
      .dec       (sec_dec),
      .tens      (st),
      .ones      (so),
      .borrow_c  (sec_borrow)
   );

   // Minutes never borrow: ALARM is entered at 00:00.
   bcd_mod60_digit_pair #(
      .TENS_MAX (MAX_MIN / 10),
      .WRAP_VAL (MAX_MIN),
      .RST_VAL  (DEFAULT_MIN)
   ) u_min (
      .clk       (CLK100Mhz),
      .rst_n     (reset_n),
      .clr       (clr_time),
      .load      (load_time),
      .load_tens (pre_mt),
      .load_ones (pre_mo),
      .inc       (min_inc),
      .dec       (sec_dec & sec_borrow),
      .tens      (mt),
      .ones      (mo),
      .borrow_c  (min_borrow_unused)
   );

   assign bus.min_tens = mt;
   assign bus.min_ones = mo;
   assign bus.sec_tens = st;
   assign bus.sec_ones = so;
   assign bus.running  = running_q;
   assign bus.alarm    = alarm_q;
   assign bus.blank    = blank_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: expected display snapshots queued at drive time, compared after the edge.
module tb_egg_timer_ctrl;
   import egg_timer_pkg::*;

   localparam int E_CLR = 1, E_START = 2, E_MIN = 4, E_SEC = 8, E_P1 = 16, E_P500 = 32;

   typedef struct {
      string       tag;
      logic [21:0] snap;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   egg_timer_ctrl_if bus();

   egg_timer_ctrl #(
      .DEFAULT_MIN (5),
      .MAX_MIN     (59),
      .ALARM_SECS  (30),
      .BLINK_DIV   (125)
   ) dut (
      .CLK100Mhz (clk),
      .reset_n   (rst_n),
      .bus       (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (mmss|state|run|alm|blk)", tag, got, exp);
   endtask

   function automatic logic [21:0] mk(input int m, input int s, input state_t st, input bit blk);
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), st,
              (st == RUN), (st == ALARM), blk};
   endfunction

   function automatic logic [21:0] obs();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.state,
              bus.running, bus.alarm, bus.blank};
   endfunction

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sb.pop_front();
         check(e.tag, 32'(obs()), 32'(e.snap));
      end
   endtask

   task automatic drive(input int ev);
      bus.btn_clear   = ev[0];
      bus.btn_start   = ev[1];
      bus.btn_min     = ev[2];
      bus.btn_sec     = ev[3];
      bus.pulse_1Hz   = ev[4];
      bus.pulse_500Hz = ev[5];
   endtask

   task automatic act(input int ev, input bit chk, input string tag,
                      input int m, input int s, input state_t st, input bit blk);
      @(negedge clk);
      drive(ev);
      if (chk) sb.push_back('{tag, mk(m, s, st, blk)});
      @(posedge clk);
      #1;
      drive(0);
      if (chk) pop_check();
   endtask

   task automatic set_time(input int m, input int s);
      act(E_CLR, 1'b0, "", 0, 0, IDLE, 1'b0);
      for (int i = 0; i < m; i++) act(E_MIN, 1'b0, "", 0, 0, IDLE, 1'b0);
      for (int i = 0; i < s; i++) act(E_SEC, 1'b0, "", 0, 0, IDLE, 1'b0);
      act(0, 1'b1, "set_time", m, s, IDLE, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      drive(0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      act(0, 1'b1, "reset", 5, 0, IDLE, 1'b0);
      for (int i = 1; i <= 300; i++) act(E_P1, i == 300, "idle_1hz", 5, 0, IDLE, 1'b0);

      act(E_CLR, 1'b1, "clear", 0, 0, IDLE, 1'b0);
      act(E_START, 1'b1, "start_zero", 0, 0, IDLE, 1'b0);
      act(E_MIN | E_SEC, 1'b1, "prio_min_sec", 1, 0, IDLE, 1'b0);
      act(E_CLR | E_START, 1'b1, "prio_clr_start", 0, 0, IDLE, 1'b0);

      for (int i = 1; i <= 59; i++) act(E_MIN, i == 59, "min_59", i, 0, IDLE, 1'b0);
      act(E_MIN, 1'b1, "min_wrap", 0, 0, IDLE, 1'b0);
      for (int i = 1; i <= 59; i++) act(E_SEC, i == 59, "sec_59", 0, i, IDLE, 1'b0);
      act(E_SEC, 1'b1, "sec_wrap_nocarry", 0, 0, IDLE, 1'b0);

      // 01:05 countdown into ALARM
      set_time(1, 5);
      act(E_START, 1'b1, "start", 1, 5, RUN, 1'b0);
      t = 65;
      for (int k = 1; k <= 65; k++) begin
         t--;
         act(E_P1, 1'b1, "run_dec", t / 60, t % 60, (t == 0) ? ALARM : RUN, 1'b0);
      end
      for (int i = 1; i <= 125; i++)
         act(E_P500, i >= 124, "blink", 0, 0, ALARM, i == 125);
      act(E_SEC, 1'b1, "alarm_btn_reload", 1, 5, IDLE, 1'b0);

      // second alarm: timeout behaviour
      act(E_START, 1'b1, "restart", 1, 5, RUN, 1'b0);
      for (int k = 1; k <= 65; k++) act(E_P1, k == 65, "rerun_alarm", 0, 0, ALARM, 1'b0);
      for (int i = 1; i <= 30; i++) begin
`ifdef EGG_ALARM_TIMEOUT_EN
         act(E_P1, i >= 29, "alarm_timeout", (i == 30) ? 1 : 0, (i == 30) ? 5 : 0,
             (i == 30) ? IDLE : ALARM, 1'b0);
`else
         act(E_P1, i >= 29, "alarm_persist", 0, 0, ALARM, 1'b0);
`endif
      end
`ifndef EGG_ALARM_TIMEOUT_EN
      act(E_CLR, 1'b1, "alarm_clr_reload", 1, 5, IDLE, 1'b0);
`endif

      set_time(10, 0);
      act(E_START, 1'b1, "start_10", 10, 0, RUN, 1'b0);
      act(E_P1, 1'b1, "dec_10_00", 9, 59, RUN, 1'b0);

      // pause / resume / simultaneous events
      set_time(2, 30);
      act(E_START, 1'b1, "start_230", 2, 30, RUN, 1'b0);
      act(E_START, 1'b1, "pause", 2, 30, PAUSE, 1'b0);
      for (int i = 1; i <= 5; i++) act(E_P1, 1'b1, "pause_hold", 2, 30, PAUSE, 1'b0);
      act(E_START, 1'b1, "resume", 2, 30, RUN, 1'b0);
      act(E_P1 | E_START, 1'b1, "dec_and_pause", 2, 29, PAUSE, 1'b0);
      act(E_START, 1'b1, "resume2", 2, 29, RUN, 1'b0);
      act(E_P1 | E_CLR, 1'b1, "clr_with_1hz", 0, 0, IDLE, 1'b0);

      set_time(0, 1);
      act(E_START, 1'b1, "start_001", 0, 1, RUN, 1'b0);
      act(E_P1 | E_CLR, 1'b1, "clr_beats_alarm", 0, 0, IDLE, 1'b0);
      act(0, 1'b1, "no_alarm_after", 0, 0, IDLE, 1'b0);

      // asynchronous reset mid-RUN
      set_time(3, 17);
      act(E_START, 1'b1, "start_317", 3, 17, RUN, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      sb.push_back('{"async_reset", mk(5, 0, IDLE, 1'b0)});
      #1;
      pop_check();
      @(negedge clk) rst_n = 1'b1;
      act(0, 1'b1, "post_reset", 5, 0, IDLE, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
